// File: rtl/nios2_soc_sysid_checker_if.sv
// Avalon-MM read channel between the sysid checker (master) and the system-ID slave.
interface nios2_soc_sysid_checker_if;
    logic        m_address;
    logic        m_read;
    logic        m_waitrequest;
    logic [31:0] m_readdata;

    modport master (
        output m_address,
        output m_read,
        input  m_waitrequest,
        input  m_readdata
    );

    modport slave (
        input  m_address,
        input  m_read,
        output m_waitrequest,
        output m_readdata
    );
endinterface

// File: rtl/nios2_soc_sysid_checker.sv
// System-ID checker: reads ID (addr 0) and timestamp (addr 1) from the sysid
// slave, compares against build-time values, retries on mismatch and reports
// sticky pass/fail. Define SYSID_CHECK_AUTOSTART_EN to self-start one run
// in the first cycle after reset is released.
module nios2_soc_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID  = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS  = 32'd1542719444,
    parameter int unsigned READ_LATENCY = 0,
    parameter int unsigned MAX_RETRIES  = 3,
    parameter int unsigned RETRY_GAP    = 16
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              start,
    nios2_soc_sysid_checker_if.master         avm,
    output logic [31:0]                       id_value,
    output logic [31:0]                       ts_value,
    output logic                              busy,
    output logic                              done,
    output logic                              pass,
    output logic                              fail,
    output logic [1:0]                        retry_count
);

    // One counter serves both the read-latency wait and the retry gap.
    localparam int unsigned CNT_MAX = (RETRY_GAP > READ_LATENCY) ? RETRY_GAP : READ_LATENCY;
    localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] LAT_N     = CNT_W'(READ_LATENCY);
    localparam logic [CNT_W-1:0] GAP_N     = CNT_W'(RETRY_GAP);
    localparam logic [CNT_W-1:0] CNT_SAT   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [1:0]       RETRY_MAX = 2'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ID,
        S_LAT_ID,
        S_RD_TS,
        S_LAT_TS,
        S_CHECK,
        S_GAP,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       retry_q, retry_d;
    logic [31:0]      id_q, id_d;
    logic [31:0]      ts_q, ts_d;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             m_read_q, m_read_d;
    logic             m_addr_q, m_addr_d;

    logic             start_eff;
    logic             accept;
    logic [CNT_W-1:0] cnt_inc;

`ifdef SYSID_CHECK_AUTOSTART_EN
    logic auto_q;

    // Armed by reset; fires once in the first cycle after reset is released.
    always_ff @(posedge clock) begin
        if (reset) begin
            auto_q <= 1'b1;
        end else begin
            auto_q <= 1'b0;
        end
    end

    assign start_eff = start | auto_q;
`else
    assign start_eff = start;
`endif

    assign accept  = m_read_q & ~avm.m_waitrequest;
    assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_ONE;

    // State register and all registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            retry_q  <= '0;
            id_q     <= '0;
            ts_q     <= '0;
            pass_q   <= 1'b0;
            fail_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            m_read_q <= 1'b0;
            m_addr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            retry_q  <= retry_d;
            id_q     <= id_d;
            ts_q     <= ts_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            m_read_q <= m_read_d;
            m_addr_q <= m_addr_d;
        end
    end

    // Next-state, capture and output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        id_d    = id_q;
        ts_d    = ts_q;
        pass_d  = pass_q;
        fail_d  = fail_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_eff) begin
                    state_d = S_RD_ID;
                    pass_d  = 1'b0;
                    fail_d  = 1'b0;
                    retry_d = '0;
                end
            end
            S_RD_ID: begin
                if (accept) begin
                    if (READ_LATENCY == 0) begin
                        id_d    = avm.m_readdata;
                        state_d = S_RD_TS;
                    end else begin
                        cnt_d   = CNT_ONE;
                        state_d = S_LAT_ID;
                    end
                end
            end
            S_LAT_ID: begin
                if (cnt_q >= LAT_N) begin
                    id_d    = avm.m_readdata;
                    state_d = S_RD_TS;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_RD_TS: begin
                if (accept) begin
                    if (READ_LATENCY == 0) begin
                        ts_d    = avm.m_readdata;
                        state_d = S_CHECK;
                    end else begin
                        cnt_d   = CNT_ONE;
                        state_d = S_LAT_TS;
                    end
                end
            end
            S_LAT_TS: begin
                if (cnt_q >= LAT_N) begin
                    ts_d    = avm.m_readdata;
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_CHECK: begin
                if ((id_q == EXPECTED_ID) && (ts_q == EXPECTED_TS)) begin
                    pass_d  = 1'b1;
                    state_d = S_DONE;
                end else if (retry_q < RETRY_MAX) begin
                    retry_d = retry_q + 2'd1;
                    cnt_d   = CNT_ONE;
                    state_d = S_GAP;
                end else begin
                    fail_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_GAP: begin
                if (cnt_q >= GAP_N) begin
                    state_d = S_RD_ID;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        m_read_d = (state_d == S_RD_ID) || (state_d == S_RD_TS);
        m_addr_d = (state_d == S_RD_TS);
        busy_d   = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d   = (state_d == S_DONE) && (state_q != S_DONE);
    end

    assign avm.m_read    = m_read_q;
    assign avm.m_address = m_addr_q;
    assign id_value      = id_q;
    assign ts_value      = ts_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign fail          = fail_q;
    assign retry_count   = retry_q;

endmodule

// File: tb/tb_nios2_soc_sysid_checker.sv
// Directed bench: instance 0 is zero-latency with a stall/corrupt-capable
// slave; instance 2 uses READ_LATENCY=2 with a pipelined slave.
module tb_nios2_soc_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'hC0DE_0001;
    localparam logic [31:0] EXP_TS = 32'd1542719444;
    localparam logic [31:0] GARB   = 32'hBAD0_BAD0;
    localparam logic [31:0] BAD_TS = 32'hDEAD_BEEF;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start0 = 1'b0;
    logic start2 = 1'b0;

    always #5 clock = ~clock;

    nios2_soc_sysid_checker_if if0 ();
    nios2_soc_sysid_checker_if if2 ();

    logic [31:0] id0, ts0, id2, ts2;
    logic        busy0, done0, pass0, fail0;
    logic        busy2, done2, pass2, fail2;
    logic [1:0]  rc0, rc2;

    nios2_soc_sysid_checker #(
        .EXPECTED_ID (EXP_ID),
        .EXPECTED_TS (EXP_TS),
        .READ_LATENCY(0),
        .MAX_RETRIES (3),
        .RETRY_GAP   (16)
    ) dut0 (
        .clock      (clock),
        .reset      (reset),
        .start      (start0),
        .avm        (if0),
        .id_value   (id0),
        .ts_value   (ts0),
        .busy       (busy0),
        .done       (done0),
        .pass       (pass0),
        .fail       (fail0),
        .retry_count(rc0)
    );

    nios2_soc_sysid_checker #(
        .EXPECTED_ID (EXP_ID),
        .EXPECTED_TS (EXP_TS),
        .READ_LATENCY(2),
        .MAX_RETRIES (3),
        .RETRY_GAP   (16)
    ) dut2 (
        .clock      (clock),
        .reset      (reset),
        .start      (start2),
        .avm        (if2),
        .id_value   (id2),
        .ts_value   (ts2),
        .busy       (busy2),
        .done       (done2),
        .pass       (pass2),
        .fail       (fail2),
        .retry_count(rc2)
    );

    // Zero-latency slave: programmable stall count on addr 0, programmable
    // number of corrupt timestamp reads; garbage whenever not accepting.
    int   wait_total  = 0;
    int   bad_total   = 0;
    int   stall_seen  = 0;
    int   ts_reads    = 0;
    logic clr         = 1'b0;
    logic [31:0] ts_ret;

    assign ts_ret            = (ts_reads < bad_total) ? BAD_TS : EXP_TS;
    assign if0.m_waitrequest = if0.m_read && !if0.m_address && (stall_seen < wait_total);
    assign if0.m_readdata    = (!if0.m_read || if0.m_waitrequest) ? GARB
                             : (if0.m_address ? ts_ret : EXP_ID);

    always @(posedge clock) begin
        if (clr) begin
            stall_seen <= 0;
            ts_reads   <= 0;
        end else begin
            if (if0.m_read && if0.m_waitrequest) stall_seen <= stall_seen + 1;
            if (if0.m_read && !if0.m_waitrequest && if0.m_address) ts_reads <= ts_reads + 1;
        end
    end

    // Latency-2 slave: data valid exactly two cycles after the accept cycle.
    logic p1v = 1'b0, p1a = 1'b0, p2v = 1'b0, p2a = 1'b0;

    assign if2.m_waitrequest = 1'b0;
    assign if2.m_readdata    = p2v ? (p2a ? EXP_TS : EXP_ID) : GARB;

    always @(posedge clock) begin
        p1v <= if2.m_read;
        p1a <= if2.m_address;
        p2v <= p1v;
        p2a <= p1a;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic cfg_slave(input int stalls, input int bad);
        wait_total = stalls;
        bad_total  = bad;
        clr        = 1'b1;
        @(posedge clock);
        #1;
        clr        = 1'b0;
    endtask

    // Raise start for 'hold' cycles; returns #1 into cycle T<hold>.
    task automatic kick(input bit which, input int hold);
        if (which) start2 = 1'b1; else start0 = 1'b1;
        repeat (hold) begin
            @(posedge clock);
            #1;
        end
        start2 = 1'b0;
        start0 = 1'b0;
    endtask

    // Watch negedges from cycle start_cyc until done; report cycle and read-strobe count.
    task automatic run_until_done(input bit which, input int start_cyc, input int budget,
                                  output int cyc, output int reads);
        bit seen;
        seen  = 1'b0;
        cyc   = start_cyc;
        reads = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clock);
            if (which ? if2.m_read : if0.m_read) reads++;
            if (which ? done2 : done0) begin
                seen = 1'b1;
                break;
            end
            cyc++;
        end
        check_eq("done_seen", 32'(seen), 32'd1);
    endtask

    int cyc, reads;

    initial begin
        cfg_slave(0, 0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_eq("rst_m_read",  32'(if0.m_read), 0);
        check_eq("rst_m_addr",  32'(if0.m_address), 0);
        check_eq("rst_busy",    32'(busy0), 0);
        check_eq("rst_done",    32'(done0), 0);
        check_eq("rst_pass",    32'(pass0), 0);
        check_eq("rst_fail",    32'(fail0), 0);
        check_eq("rst_retry",   32'(rc0), 0);
        check_eq("rst_id",      id0, 0);
        check_eq("rst_ts",      ts0, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_eq("no_autostart_busy", 32'(busy0), 0);

        // 1: clean run, done/pass at T4
        kick(0, 1);
        run_until_done(0, 1, 50, cyc, reads);
        check_eq("t1_cycle",  32'(cyc), 32'd4);
        check_eq("t1_reads",  32'(reads), 32'd2);
        check_eq("t1_pass",   32'(pass0), 1);
        check_eq("t1_fail",   32'(fail0), 0);
        check_eq("t1_busy",   32'(busy0), 0);
        check_eq("t1_retry",  32'(rc0), 0);
        check_eq("t1_id",     id0, EXP_ID);
        check_eq("t1_ts",     ts0, EXP_TS);
        @(negedge clock);
        check_eq("t1_done_pulse", 32'(done0), 0);
        check_eq("t1_pass_sticky", 32'(pass0), 1);

        // 2: three stall cycles on addr 0
        cfg_slave(3, 0);
        kick(0, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check_eq("t2_stall_read", 32'(if0.m_read), 1);
            check_eq("t2_stall_addr", 32'(if0.m_address), 0);
            check_eq("t2_stall_id",   id0, EXP_ID);
        end
        run_until_done(0, 4, 50, cyc, reads);
        check_eq("t2_cycle", 32'(cyc), 32'd7);
        check_eq("t2_reads", 32'(reads), 32'd2);
        check_eq("t2_pass",  32'(pass0), 1);
        check_eq("t2_id",    id0, EXP_ID);

        // 3: timestamp always wrong -> 4 attempts, 3 gaps of 16
        cfg_slave(0, 1000);
        kick(0, 1);
        run_until_done(0, 1, 200, cyc, reads);
        check_eq("t3_cycle", 32'(cyc), 32'd61);
        check_eq("t3_reads", 32'(reads), 32'd8);
        check_eq("t3_fail",  32'(fail0), 1);
        check_eq("t3_pass",  32'(pass0), 0);
        check_eq("t3_retry", 32'(rc0), 3);
        check_eq("t3_ts",    ts0, BAD_TS);
        check_eq("t3_busy",  32'(busy0), 0);

        // 4: first attempt bad, second good; start held into RD_ID is ignored
        cfg_slave(0, 1);
        kick(0, 2);
        run_until_done(0, 2, 100, cyc, reads);
        check_eq("t4_cycle", 32'(cyc), 32'd23);
        check_eq("t4_reads", 32'(reads), 32'd3);
        check_eq("t4_pass",  32'(pass0), 1);
        check_eq("t4_fail",  32'(fail0), 0);
        check_eq("t4_retry", 32'(rc0), 1);
        check_eq("t4_ts",    ts0, EXP_TS);

        // 5: READ_LATENCY=2 instance
        kick(1, 1);
        run_until_done(1, 1, 50, cyc, reads);
        check_eq("t5_cycle", 32'(cyc), 32'd8);
        check_eq("t5_reads", 32'(reads), 32'd2);
        check_eq("t5_id",    id2, EXP_ID);
        check_eq("t5_ts",    ts2, EXP_TS);
        check_eq("t5_pass",  32'(pass2), 1);
        check_eq("t5_fail",  32'(fail2), 0);

        // 6: reset during RD_TS
        cfg_slave(0, 0);
        kick(0, 1);
        @(posedge clock);
        #1;
        check_eq("t6_rdts_read", 32'(if0.m_read), 1);
        check_eq("t6_rdts_addr", 32'(if0.m_address), 1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_eq("t6_rst_read", 32'(if0.m_read), 0);
        check_eq("t6_rst_addr", 32'(if0.m_address), 0);
        check_eq("t6_rst_busy", 32'(busy0), 0);
        check_eq("t6_rst_id",   id0, 0);
        check_eq("t6_rst_pass", 32'(pass0), 0);
        check_eq("t6_rst_done", 32'(done0), 0);
        reset = 1'b0;
        @(posedge clock);
        #1;
        kick(0, 1);
        run_until_done(0, 1, 50, cyc, reads);
        check_eq("t6_cycle", 32'(cyc), 32'd4);
        check_eq("t6_pass",  32'(pass0), 1);
        check_eq("t6_id",    id0, EXP_ID);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
